// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with a manual select mode and a
// round-robin scan mode. Scanning dwells DWELL cycles per enabled channel,
// can be frozen with hold, and flags each wrap back to a lower channel.
// o, o_ch, o_valid and wrap are registered together on the same edge,
// so they always describe the same channel.
module mux_scan_n #(
    parameter  int WIDTH = 32,
    parameter  int N     = 8,
    parameter  int DWELL = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   din,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    input  logic [N-1:0]         en_mask,
    input  logic                 hold,
    output logic [WIDTH-1:0]     o,
    output logic [SEL_W-1:0]     o_ch,
    output logic                 o_valid,
    output logic                 wrap
);

    localparam int CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int MASK_W = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {MANUAL, SCAN, PARK} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   o_d;
    logic [SEL_W-1:0]   o_ch_d;
    logic               o_valid_d;
    logic               wrap_d;
    logic [MASK_W-1:0]  mask_ext;
    logic [SEL_W-1:0]   adv_ch;

    // First enabled channel at or after 'from' (incl=1) or strictly after it
    // (incl=0), modulo N. 'from' may exceed N-1 after a manual out-of-range
    // select, hence the modulo on the starting point. With a single enabled
    // channel the strict search lands back on that channel.
    function automatic logic [SEL_W-1:0] next_enabled(
        input logic [SEL_W-1:0] from,
        input logic [N-1:0]     mask,
        input logic             incl
    );
        logic [SEL_W-1:0] res;
        logic             found;
        int               base;
        int               idx;
        res   = from;
        found = 1'b0;
        base  = int'(from) % N;
        for (int i = 0; i < N; i++) begin
            idx = (base + i + (incl ? 0 : 1)) % N;
            if (!found && mask[idx]) begin
                res   = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Channel slice extraction; channels at or above N read as zero.
    function automatic logic [WIDTH-1:0] chan_data(
        input logic [N*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]   ch
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(ch) == k) res = bus[k*WIDTH +: WIDTH];
        end
        return res;
    endfunction

    // Next state, channel pointer, dwell counter and output values.
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        cnt_d     = cnt_q;
        o_d       = o;
        o_ch_d    = o_ch;
        o_valid_d = o_valid;
        wrap_d    = 1'b0;

        // Mask widened to the full select range: bits >= N stay zero, so an
        // out-of-range manual select reads as a disabled channel.
        mask_ext            = '0;
        mask_ext[N-1:0]     = en_mask;
        adv_ch              = next_enabled(cur_ch_q, en_mask, 1'b0);

        if (!mode) begin
            state_d  = MANUAL;
            cur_ch_d = sel;
            cnt_d    = '0;
            o_ch_d   = sel;
            if (mask_ext[sel]) begin
                o_d       = chan_data(din, sel);
                o_valid_d = 1'b1;
            end else begin
                o_d       = '0;
                o_valid_d = 1'b0;
            end
        end else if (en_mask == '0) begin
            state_d   = PARK;
            cnt_d     = '0;
            o_d       = '0;
            o_valid_d = 1'b0;
        end else begin
            state_d = SCAN;
            if (state_q != SCAN) begin
                // Entry: start on the first enabled channel from where we are.
                cur_ch_d = next_enabled(cur_ch_q, en_mask, 1'b1);
                cnt_d    = '0;
            end else if (!mask_ext[cur_ch_q] ||
                         (!hold && cnt_q == CNT_LAST)) begin
                // Mask-out (overrides hold) or end of dwell: move on.
                cur_ch_d = adv_ch;
                cnt_d    = '0;
                wrap_d   = (adv_ch < cur_ch_q);
            end else if (!hold) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            o_d       = chan_data(din, cur_ch_d);
            o_ch_d    = cur_ch_d;
            o_valid_d = 1'b1;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= MANUAL;
            cur_ch_q <= '0;
            cnt_q    <= '0;
            o        <= '0;
            o_ch     <= '0;
            o_valid  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            cnt_q    <= cnt_d;
            o        <= o_d;
            o_ch     <= o_ch_d;
            o_valid  <= o_valid_d;
            wrap     <= wrap_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: a default 8x32 instance with DWELL=4,
// a minimal 2x1 instance with DWELL=1, and a 16x8 instance.
module tb_mux_scan_n;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance A: N=8, WIDTH=32, DWELL=4
    logic [8*32-1:0] din_a;
    logic [2:0]      sel_a;
    logic            mode_a, hold_a;
    logic [7:0]      en_a;
    logic [31:0]     o_a;
    logic [2:0]      o_ch_a;
    logic            o_valid_a, wrap_a;

    // Instance B: N=2, WIDTH=1, DWELL=1
    logic [1:0]      din_b;
    logic [0:0]      sel_b;
    logic            mode_b, hold_b;
    logic [1:0]      en_b;
    logic [0:0]      o_b;
    logic [0:0]      o_ch_b;
    logic            o_valid_b, wrap_b;

    // Instance C: N=16, WIDTH=8, DWELL=4
    logic [16*8-1:0] din_c;
    logic [3:0]      sel_c;
    logic            mode_c, hold_c;
    logic [15:0]     en_c;
    logic [7:0]      o_c;
    logic [3:0]      o_ch_c;
    logic            o_valid_c, wrap_c;

    mux_scan_n #(.WIDTH(32), .N(8), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel_a), .mode(mode_a),
        .en_mask(en_a), .hold(hold_a), .o(o_a), .o_ch(o_ch_a),
        .o_valid(o_valid_a), .wrap(wrap_a));

    mux_scan_n #(.WIDTH(1), .N(2), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .sel(sel_b), .mode(mode_b),
        .en_mask(en_b), .hold(hold_b), .o(o_b), .o_ch(o_ch_b),
        .o_valid(o_valid_b), .wrap(wrap_b));

    mux_scan_n #(.WIDTH(8), .N(16), .DWELL(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din_c), .sel(sel_c), .mode(mode_c),
        .en_mask(en_c), .hold(hold_c), .o(o_c), .o_ch(o_ch_c),
        .o_valid(o_valid_c), .wrap(wrap_c));

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [37:0] exp_v;
        #1 rst_n = 1'b0;
        #1;
        exp_v = '0;
        n_assert++;
        if ({o_a, o_ch_a, o_valid_a, wrap_a} !== exp_v[36:0]) begin
            n_fail++;
            $display("FAIL reset_async_a got o=%h ch=%0d v=%b w=%b, want all zero",
                     o_a, o_ch_a, o_valid_a, wrap_a);
        end
        n_assert++;
        if ({o_ch_b, o_valid_b, wrap_b, o_ch_c, o_valid_c, wrap_c} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_async_bc got b_ch=%0d c_ch=%0d, want zero outputs",
                     o_ch_b, o_ch_c);
        end
        step();
        step();
        rst_n = 1'b1;
        sel_a = 3'd1;
        step();
        n_assert++;
        if ({o_a, o_ch_a, o_valid_a, wrap_a} !== {32'h1000_0001, 3'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_first_edge got o=%h ch=%0d v=%b, want 10000001/1/1",
                     o_a, o_ch_a, o_valid_a);
        end
    endtask

    task automatic test_manual();
        for (int k = 0; k < 8; k++) begin
            sel_a = 3'(k);
            step();
            n_assert++;
            if ({o_a, o_ch_a, o_valid_a, wrap_a} !==
                {32'h1000_0000 + 32'(k), 3'(k), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL manual_sel%0d got o=%h ch=%0d v=%b w=%b", k,
                         o_a, o_ch_a, o_valid_a, wrap_a);
            end
        end
        en_a  = 8'hF7;
        sel_a = 3'd3;
        step();
        n_assert++;
        if ({o_a, o_ch_a, o_valid_a, wrap_a} !== {32'h0, 3'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL manual_masked got o=%h ch=%0d v=%b, want 0/3/0",
                     o_a, o_ch_a, o_valid_a);
        end
    endtask

    task automatic test_scan();
        logic [2:0] seq [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [2:0] ch;
        logic       w;
        sel_a = 3'd0;
        en_a  = 8'hFF;
        step();
        mode_a = 1'b1;
        en_a   = 8'hA5;
        for (int j = 0; j < 36; j++) begin
            step();
            ch = seq[(j / 4) % 4];
            w  = (j > 0) && (j % 16 == 0);
            n_assert++;
            if ({o_a, o_ch_a, o_valid_a, wrap_a} !==
                {32'h1000_0000 + 32'(ch), ch, 1'b1, w}) begin
                n_fail++;
                $display("FAIL scan_cycle%0d got ch=%0d o=%h w=%b, want ch=%0d w=%b",
                         j, o_ch_a, o_a, wrap_a, ch, w);
            end
        end
    endtask

    task automatic test_single_empty();
        en_a = 8'h10;
        for (int j = 0; j < 12; j++) begin
            step();
            n_assert++;
            if ({o_a, o_ch_a, o_valid_a, wrap_a} !== {32'h1000_0004, 3'd4, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL single_ch cycle%0d got ch=%0d w=%b, want ch=4 w=0",
                         j, o_ch_a, wrap_a);
            end
        end
        en_a = 8'h00;
        for (int j = 0; j < 2; j++) begin
            step();
            n_assert++;
            if ({o_a, o_ch_a, o_valid_a, wrap_a} !== {32'h0, 3'd4, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL park cycle%0d got o=%h ch=%0d v=%b, want 0/4/0",
                         j, o_a, o_ch_a, o_valid_a);
            end
        end
        en_a = 8'h01;
        step();
        n_assert++;
        if ({o_a, o_ch_a, o_valid_a, wrap_a} !== {32'h1000_0000, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL park_exit got o=%h ch=%0d v=%b w=%b, want 10000000/0/1/0",
                     o_a, o_ch_a, o_valid_a, wrap_a);
        end
    endtask

    task automatic test_hold_mask();
        mode_a = 1'b0;
        sel_a  = 3'd2;
        en_a   = 8'hFF;
        step();
        mode_a = 1'b1;
        en_a   = 8'hA5;
        step();
        hold_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din_a[2*32 +: 32] = 32'h2000_0000 + 32'(i);
            step();
            n_assert++;
            if ({o_a, o_ch_a, o_valid_a, wrap_a} !==
                {32'h2000_0000 + 32'(i), 3'd2, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold cycle%0d got o=%h ch=%0d, want %h/2",
                         i, o_a, o_ch_a, 32'h2000_0000 + 32'(i));
            end
        end
        en_a = 8'hA1;
        step();
        n_assert++;
        if ({o_a, o_ch_a, o_valid_a, wrap_a} !== {32'h1000_0005, 3'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL maskout_advance got ch=%0d v=%b w=%b, want 5/1/0",
                     o_ch_a, o_valid_a, wrap_a);
        end
        hold_a = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            n_assert++;
            if (o_ch_a !== ((j < 3) ? 3'd5 : 3'd7)) begin
                n_fail++;
                $display("FAIL maskout_dwell cycle%0d got ch=%0d, want %0d",
                         j, o_ch_a, (j < 3) ? 5 : 7);
            end
        end
    endtask

    task automatic test_reset_midscan();
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({o_a, o_ch_a, o_valid_a, wrap_a} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_midscan got o=%h ch=%0d v=%b w=%b, want all zero",
                     o_a, o_ch_a, o_valid_a, wrap_a);
        end
        mode_a = 1'b0;
        sel_a  = 3'd6;
        en_a   = 8'hFF;
        #2 rst_n = 1'b1;
        step();
        n_assert++;
        if ({o_a, o_ch_a, o_valid_a, wrap_a} !== {32'h1000_0006, 3'd6, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_resume_manual got o=%h ch=%0d v=%b, want 10000006/6/1",
                     o_a, o_ch_a, o_valid_a);
        end
    endtask

    task automatic test_small();
        logic c;
        logic w;
        sel_b = 1'b1;
        step();
        n_assert++;
        if ({o_b, o_ch_b, o_valid_b, wrap_b} !== 4'b1110) begin
            n_fail++;
            $display("FAIL small_manual got o=%b ch=%0d v=%b, want 1/1/1",
                     o_b, o_ch_b, o_valid_b);
        end
        sel_b = 1'b0;
        step();
        mode_b = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            c = 1'(j % 2);
            w = (j > 0) && (j % 2 == 0);
            n_assert++;
            if ({o_b, o_ch_b, o_valid_b, wrap_b} !== {c, c, 1'b1, w}) begin
                n_fail++;
                $display("FAIL small_scan cycle%0d got ch=%0d w=%b, want ch=%0d w=%b",
                         j, o_ch_b, wrap_b, c, w);
            end
        end
    endtask

    task automatic test_wide();
        logic [3:0] ch;
        logic       w;
        for (int k = 0; k < 16; k++) begin
            sel_c = 4'(k);
            step();
            n_assert++;
            if ({o_c, o_ch_c, o_valid_c, wrap_c} !== {8'hA0 + 8'(k), 4'(k), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL wide_manual sel%0d got o=%h ch=%0d", k, o_c, o_ch_c);
            end
        end
        sel_c = 4'd0;
        step();
        mode_c = 1'b1;
        for (int j = 0; j < 65; j++) begin
            step();
            ch = 4'((j / 4) % 16);
            w  = (j == 64);
            n_assert++;
            if ({o_c, o_ch_c, o_valid_c, wrap_c} !== {8'hA0 + 8'(ch), ch, 1'b1, w}) begin
                n_fail++;
                $display("FAIL wide_scan cycle%0d got ch=%0d o=%h w=%b, want ch=%0d w=%b",
                         j, o_ch_c, o_c, wrap_c, ch, w);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) din_a[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        for (int k = 0; k < 16; k++) din_c[k*8 +: 8] = 8'hA0 + 8'(k);
        din_b  = 2'b10;
        sel_a  = '0; mode_a = 1'b0; hold_a = 1'b0; en_a = 8'hFF;
        sel_b  = '0; mode_b = 1'b0; hold_b = 1'b0; en_b = 2'b11;
        sel_c  = '0; mode_c = 1'b0; hold_c = 1'b0; en_c = 16'hFFFF;

        test_reset();
        test_manual();
        test_scan();
        test_single_empty();
        test_hold_mask();
        test_reset_midscan();
        test_small();
        test_wide();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
